// File: rtl/reg_bank_if.sv
// Register bank access bundle: one write port and two read ports.
// Width parameters must match the reg_bank instance they connect to.
interface reg_bank_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              write_enable;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] r_a;
    logic [ADDR_W-1:0] r_b;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;

    modport master (
        output write_enable,
        output write_addr,
        output write_data,
        output r_a,
        output r_b,
        input  a,
        input  b
    );

    modport slave (
        input  write_enable,
        input  write_addr,
        input  write_data,
        input  r_a,
        input  r_b,
        output a,
        output b
    );
endinterface

// File: rtl/reg_bank.sv
// General-purpose register file, two async read ports, one sync write port.
// Define REG_BANK_BYPASS_EN to forward write_data onto matching read ports.
module reg_bank #(
    parameter int              DATA_W    = 8,
    parameter int              ADDR_W    = 2,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic       clk,
    input  logic       rst,
    reg_bank_if.slave  bus
);
    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (bus.write_enable) begin
            regs[bus.write_addr] <= bus.write_data;
        end
    end

`ifdef REG_BANK_BYPASS_EN
    logic fwd_ok;

    assign fwd_ok = bus.write_enable && !rst;

    always_comb begin
        bus.a = regs[bus.r_a];
        bus.b = regs[bus.r_b];
        if (fwd_ok && (bus.r_a == bus.write_addr)) begin
            bus.a = bus.write_data;
        end
        if (fwd_ok && (bus.r_b == bus.write_addr)) begin
            bus.b = bus.write_data;
        end
    end
`else
    always_comb begin
        bus.a = regs[bus.r_a];
        bus.b = regs[bus.r_b];
    end
`endif
endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank (4 x 8-bit default configuration).
// Table-driven vectors plus hand sequences for read-during-write and reset.
module tb_reg_bank;
    logic clk;
    logic rst;

    reg_bank_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    reg_bank #(.DATA_W(8), .ADDR_W(2), .RESET_VAL(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       we;
        logic [1:0] wa;
        logic [7:0] wd;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;

    function automatic vec_t mk(string n, logic r, logic w,
                                logic [1:0] wa, logic [7:0] wd,
                                logic [1:0] ra, logic [1:0] rb,
                                logic [7:0] ea, logic [7:0] eb);
        vec_t v;
        v.name = n; v.rst = r; v.we = w; v.wa = wa; v.wd = wd;
        v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    task automatic check(string n, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(logic r, logic w, logic [1:0] wa,
                         logic [7:0] wd, logic [1:0] ra, logic [1:0] rb);
        rst              = r;
        bus.write_enable = w;
        bus.write_addr   = wa;
        bus.write_data   = wd;
        bus.r_a          = ra;
        bus.r_b          = rb;
    endtask

    logic [7:0] model [4];
    logic [7:0] exp_pre;

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 2'd0);

        vecs.push_back(mk("init_rst", 1, 0, 0, 8'h00, 0, 3, 8'h00, 8'h00));
        vecs.push_back(mk("wr_aa_r2", 0, 1, 2, 8'hAA, 2, 2, 8'hAA, 8'hAA));
        vecs.push_back(mk("rst_clr",  1, 0, 0, 8'h00, 2, 2, 8'h00, 8'h00));
        vecs.push_back(mk("sweep_01", 0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00));
        vecs.push_back(mk("sweep_23", 0, 0, 0, 8'h00, 2, 3, 8'h00, 8'h00));
        vecs.push_back(mk("rst_vs_wr",1, 1, 1, 8'h77, 1, 1, 8'h00, 8'h00));
        vecs.push_back(mk("r1_still0",0, 0, 1, 8'h00, 1, 1, 8'h00, 8'h00));
        vecs.push_back(mk("wr0_a0",   0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        vecs.push_back(mk("wr0_a1",   0, 1, 1, 8'h00, 1, 1, 8'h00, 8'h00));
        vecs.push_back(mk("wr0_a2",   0, 1, 2, 8'h00, 2, 2, 8'h00, 8'h00));
        vecs.push_back(mk("wr0_a3",   0, 1, 3, 8'h00, 3, 3, 8'h00, 8'h00));
        vecs.push_back(mk("wr_f5_a0", 0, 1, 0, 8'hF5, 0, 1, 8'hF5, 8'h00));
        vecs.push_back(mk("wr_53_a3", 0, 1, 3, 8'h53, 0, 3, 8'hF5, 8'h53));
        vecs.push_back(mk("others0",  0, 0, 0, 8'h00, 1, 2, 8'h00, 8'h00));
        vecs.push_back(mk("we0_ff_1", 0, 0, 2, 8'hFF, 2, 2, 8'h00, 8'h00));
        vecs.push_back(mk("we0_ff_2", 0, 0, 2, 8'hFF, 2, 2, 8'h00, 8'h00));
        vecs.push_back(mk("we0_ff_3", 0, 0, 2, 8'hFF, 2, 0, 8'h00, 8'hF5));
        vecs.push_back(mk("wr_11_a1", 0, 1, 1, 8'h11, 1, 0, 8'h11, 8'hF5));
        vecs.push_back(mk("b2b_10",   0, 1, 2, 8'h10, 2, 2, 8'h10, 8'h10));
        vecs.push_back(mk("b2b_20",   0, 1, 2, 8'h20, 2, 2, 8'h20, 8'h20));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].we, vecs[i].wa,
                  vecs[i].wd, vecs[i].ra, vecs[i].rb);
            @(posedge clk);
            #1;
            check({vecs[i].name, ".a"}, bus.a, vecs[i].ea);
            check({vecs[i].name, ".b"}, bus.b, vecs[i].eb);
        end

        // Read-during-write on r1 (holds 0x11), b watches untouched r3.
        @(negedge clk);
        drive(1'b0, 1'b1, 2'd1, 8'h22, 2'd1, 2'd3);
        #1;
`ifdef REG_BANK_BYPASS_EN
        exp_pre = 8'h22;
`else
        exp_pre = 8'h11;
`endif
        check("rdw_pre.a", bus.a, exp_pre);
        check("rdw_pre.b", bus.b, 8'h53);
        @(posedge clk);
        #1;
        check("rdw_post.a", bus.a, 8'h22);

        // Zero-latency address sweep with no edges in between.
        model[0] = 8'hF5; model[1] = 8'h22;
        model[2] = 8'h20; model[3] = 8'h53;
        @(negedge clk);
        bus.write_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.r_a = 2'(i);
            bus.r_b = 2'(3 - i);
            #1;
            check($sformatf("comb_sweep%0d.a", i), bus.a, model[i]);
            check($sformatf("comb_sweep%0d.b", i), bus.b, model[3 - i]);
        end

        // Reset with a pending write: no forwarding, write dropped.
        @(negedge clk);
        drive(1'b1, 1'b1, 2'd3, 8'h99, 2'd0, 2'd3);
        #1;
        check("rst_wr_pre.b", bus.b, 8'h53);
        @(posedge clk);
        #1;
        check("rst_wr_post.a", bus.a, 8'h00);
        check("rst_wr_post.b", bus.b, 8'h00);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 2'd2);
        #1;
        check("post_rst.a", bus.a, 8'h00);
        check("post_rst.b", bus.b, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
